// File: rtl/pciedma_pkg.sv
// Shared constants, FSM state type and helpers for the pciedma completion transmitter.
package pciedma_pkg;

  localparam logic [7:0] FMT_TYPE_CPLD = 8'h4A;
  localparam logic [7:0] FMT_TYPE_CPL  = 8'h0A;
  localparam logic [2:0] CPL_SC        = 3'b000;
  localparam logic [2:0] CPL_UR        = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRED,
    ST_REQ,
    ST_HDR,
    ST_DATA
  } cpl_state_t;

  // Six header halfwords; element 0 goes on the wire first.
  typedef logic [5:0][15:0] cpl_hdr_t;

  // Data credits (16-byte units) needed for a read of len_dw DWs.
  function automatic logic [8:0] cpld_needed(input logic [9:0] len_dw);
    logic [10:0] sum;
    sum = {1'b0, len_dw} + 11'd3;
    return sum[10:2];
  endfunction

endpackage

// File: rtl/pcie_cpl_tx_if.sv
// Request channel from the RX parser plus VC0 completion TX channel of pcie_top.
interface pcie_cpl_tx_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_id;
  logic [7:0]  req_tag;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [9:0]  req_len_dw;
  logic [11:0] req_addr;

  logic [8:0]  tx_ca_cplh;
  logic [12:0] tx_ca_cpld;
  logic        tx_ca_cpl_recheck;
  logic        tx_req;
  logic        tx_rdy;
  logic        tx_st;
  logic        tx_end;
  logic [15:0] tx_data;

  // master: the completer that sources completion TLPs
  modport master (
    input  req_valid, req_id, req_tag, req_tc, req_attr, req_len_dw, req_addr,
    input  tx_ca_cplh, tx_ca_cpld, tx_ca_cpl_recheck, tx_rdy,
    output req_ready, tx_req, tx_st, tx_end, tx_data
  );

  modport slave (
    output req_valid, req_id, req_tag, req_tc, req_attr, req_len_dw, req_addr,
    output tx_ca_cplh, tx_ca_cpld, tx_ca_cpl_recheck, tx_rdy,
    input  req_ready, tx_req, tx_st, tx_end, tx_data
  );
endinterface

// File: rtl/pcie_cpl_hdr.sv
// Combinational builder of the 3-DW completion header (CplD or UR Cpl) from latched request fields.
module pcie_cpl_hdr
  import pciedma_pkg::*;
(
  input  logic [7:0]  bus_num,
  input  logic [4:0]  dev_num,
  input  logic [2:0]  func_num,
  input  logic [2:0]  tc,
  input  logic [1:0]  attr,
  input  logic [9:0]  len_dw,
  input  logic [7:0]  tag,
  input  logic [15:0] req_id,
  input  logic [6:0]  addr_lo,
  input  logic        ur,
  output cpl_hdr_t    hdr
);

  logic [9:0]  len_f;
  logic [11:0] byte_cnt;

  always_comb begin
    // UR carries no payload: length 0, byte count fixed at 4
    len_f    = ur ? '0 : len_dw;
    byte_cnt = ur ? 12'd4 : {len_dw, 2'b00};
    hdr[0]   = {(ur ? FMT_TYPE_CPL : FMT_TYPE_CPLD), 1'b0, tc, 4'b0000};
    hdr[1]   = {2'b00, attr, 2'b00, len_f};
    hdr[2]   = {bus_num, dev_num, func_num};
    hdr[3]   = {(ur ? CPL_UR : CPL_SC), 1'b0, byte_cnt};
    hdr[4]   = req_id;
    hdr[5]   = {tag, 1'b0, addr_lo};
  end

endmodule

// File: rtl/pcie_cpl_tx.sv
// Completion transmitter: accepts decoded memory reads, checks credits, emits CplD/UR Cpl on VC0 TX.
module pcie_cpl_tx
  import pciedma_pkg::*;
#(
  parameter int MAX_LEN_DW = 16,
  parameter int ADDR_W     = 11
) (
  input  logic              pcie_clk,
  input  logic              sys_rst,
  input  logic [7:0]        bus_num,
  input  logic [4:0]        dev_num,
  input  logic [2:0]        func_num,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  pcie_cpl_tx_if.master     cpl
);

  cpl_state_t        state, state_d;
  logic [10:0]       cnt, cnt_d;
  logic              tx_req_d, tx_st_d, tx_end_d;
  logic [15:0]       tx_data_d;
  logic [ADDR_W-1:0] rd_addr_d;

  logic [15:0] id_q;
  logic [7:0]  tag_q;
  logic [2:0]  tc_q;
  logic [1:0]  attr_q;
  logic [9:0]  len_q;
  logic [11:0] addr_q;
  logic        addr_unused;

  logic        ur;
  logic        cred_ok;
  cpl_hdr_t    hdr;

  assign cpl.req_ready = (state == ST_IDLE) & ~sys_rst;
  assign ur            = (len_q == '0) || (len_q > 10'(MAX_LEN_DW));
  assign addr_unused   = ^addr_q;

  assign cred_ok = (cpl.tx_ca_cplh != '0) &&
                   (ur || cpl.tx_ca_cpld[12] ||
                    ({3'b000, cpld_needed(len_q)} <= cpl.tx_ca_cpld[11:0]));

  always_ff @(posedge pcie_clk) begin
    if (cpl.req_valid && cpl.req_ready) begin
      id_q   <= cpl.req_id;
      tag_q  <= cpl.req_tag;
      tc_q   <= cpl.req_tc;
      attr_q <= cpl.req_attr;
      len_q  <= cpl.req_len_dw;
      addr_q <= cpl.req_addr;
    end
  end

  pcie_cpl_hdr u_hdr (
    .bus_num  (bus_num),
    .dev_num  (dev_num),
    .func_num (func_num),
    .tc       (tc_q),
    .attr     (attr_q),
    .len_dw   (len_q),
    .tag      (tag_q),
    .req_id   (id_q),
    .addr_lo  (addr_q[6:0]),
    .ur       (ur),
    .hdr      (hdr)
  );

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cpl.tx_req  <= 1'b0;
      cpl.tx_st   <= 1'b0;
      cpl.tx_end  <= 1'b0;
      cpl.tx_data <= '0;
      rd_addr     <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      cpl.tx_req  <= tx_req_d;
      cpl.tx_st   <= tx_st_d;
      cpl.tx_end  <= tx_end_d;
      cpl.tx_data <= tx_data_d;
      rd_addr     <= rd_addr_d;
    end
  end

  // Outputs are registered, so each state computes the halfword shown in the following cycle.
  // BRAM base goes out two cycles ahead of the first data word to cover its read latency.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    tx_req_d  = 1'b0;
    tx_st_d   = 1'b0;
    tx_end_d  = 1'b0;
    tx_data_d = '0;
    rd_addr_d = rd_addr;
    unique case (state)
      ST_IDLE: begin
        if (cpl.req_valid) state_d = ST_CRED;
      end
      ST_CRED: begin
        if (cred_ok) begin
          state_d  = ST_REQ;
          tx_req_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (cpl.tx_ca_cpl_recheck) begin
          state_d = ST_CRED;
        end else if (cpl.tx_rdy) begin
          state_d   = ST_HDR;
          tx_st_d   = 1'b1;
          tx_data_d = hdr[0];
          cnt_d     = 11'd1;
        end else begin
          tx_req_d = 1'b1;
        end
      end
      ST_HDR: begin
        tx_data_d = hdr[cnt[2:0]];
        cnt_d     = cnt + 11'd1;
        if (cnt == 11'd4 && !ur) rd_addr_d = addr_q[ADDR_W:1];
        if (cnt == 11'd5) begin
          if (ur) begin
            tx_end_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            rd_addr_d = rd_addr + ADDR_W'(1);
          end
        end
      end
      ST_DATA: begin
        tx_data_d = rd_data;
        rd_addr_d = rd_addr + ADDR_W'(1);
        cnt_d     = cnt + 11'd1;
        if (cnt == ({len_q, 1'b0} - 11'd1)) begin
          tx_end_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
